// File: rtl/imem_dmem_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
// The fairness streak counter is only built when ARB_FAIRNESS_EN is defined.
package imem_dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_I    = 2'b01;
    localparam logic [1:0] GNT_D    = 2'b10;

    localparam int unsigned STREAK_W = 4;

endpackage

// File: rtl/arb_grant_sel.sv
// One-hot grant selection between fetch and data requesters.
// Data wins unless the data streak has reached MAX_DATA_STREAK while fetch is eligible.
module arb_grant_sel
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                i_elig,
    input  logic                d_elig,
    input  logic [STREAK_W-1:0] streak,
    output logic [1:0]          gnt
);

    logic fetch_turn;

    // streak is tied to zero without fairness, and MAX_DATA_STREAK >= 1, so this never fires there
    assign fetch_turn = i_elig && (streak == STREAK_W'(MAX_DATA_STREAK));

    always_comb begin
        gnt = GNT_NONE;
        if (d_elig && !fetch_turn) begin
            gnt = GNT_D;
        end else if (i_elig) begin
            gnt = GNT_I;
        end
    end

endmodule

// File: rtl/imem_dmem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Define ARB_FAIRNESS_EN to bound consecutive data grants while fetch waits.
module imem_dmem_arbiter
    import imem_dmem_arbiter_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH   = 32,
    parameter int unsigned MAX_DATA_STREAK = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_req,
    input  logic [WORD_BITWIDTH-1:0]   i_addr,
    output logic                       i_ready,
    output logic [WORD_BITWIDTH-1:0]   i_rdata,
    input  logic                       d_req,
    input  logic                       d_we,
    input  logic [WORD_BITWIDTH-1:0]   d_addr,
    input  logic [WORD_BITWIDTH-1:0]   d_wdata,
    input  logic [WORD_BITWIDTH/8-1:0] d_wstrb,
    output logic                       d_ready,
    output logic [WORD_BITWIDTH-1:0]   d_rdata,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [WORD_BITWIDTH-1:0]   mem_addr,
    output logic [WORD_BITWIDTH-1:0]   mem_wdata,
    output logic [WORD_BITWIDTH/8-1:0] mem_wstrb,
    input  logic                       mem_ready,
    input  logic [WORD_BITWIDTH-1:0]   mem_rdata,
    output logic                       if_stall,
    output logic                       mem_stall
);

    localparam int unsigned STRB_W = WORD_BITWIDTH / 8;

    arb_state_t                state_q, state_d;
    logic                      mem_req_q, mem_req_d;
    logic                      mem_we_q, mem_we_d;
    logic [WORD_BITWIDTH-1:0]  mem_addr_q, mem_addr_d;
    logic [WORD_BITWIDTH-1:0]  mem_wdata_q, mem_wdata_d;
    logic [STRB_W-1:0]         mem_wstrb_q, mem_wstrb_d;
    logic                      i_ready_q, i_ready_d;
    logic                      d_ready_q, d_ready_d;
    logic [WORD_BITWIDTH-1:0]  i_rdata_q, i_rdata_d;
    logic [WORD_BITWIDTH-1:0]  d_rdata_q, d_rdata_d;

    logic                      i_elig, d_elig;
    logic [1:0]                gnt;
    logic [STREAK_W-1:0]       streak;

    // A requester whose ready pulse is high is still holding req; it must not be re-granted.
    assign i_elig = i_req && !i_ready_q;
    assign d_elig = d_req && !d_ready_q;

    arb_grant_sel #(
        .MAX_DATA_STREAK(MAX_DATA_STREAK)
    ) u_grant_sel (
        .i_elig (i_elig),
        .d_elig (d_elig),
        .streak (streak),
        .gnt    (gnt)
    );

`ifdef ARB_FAIRNESS_EN
    logic [STREAK_W-1:0] streak_q, streak_d;

    always_comb begin
        streak_d = streak_q;
        if (state_q == IDLE) begin
            if (gnt == GNT_I) begin
                streak_d = '0;
            end else if (gnt == GNT_D && i_req && streak_q != '1) begin
                streak_d = streak_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) streak_q <= '0;
        else     streak_q <= streak_d;
    end

    assign streak = streak_q;
`else
    assign streak = '0;
`endif

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wstrb_d = mem_wstrb_q;
        i_rdata_d   = i_rdata_q;
        d_rdata_d   = d_rdata_q;
        i_ready_d   = 1'b0;
        d_ready_d   = 1'b0;

        case (state_q)
            IDLE: begin
                mem_req_d = 1'b0;
                if (gnt == GNT_D) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_wstrb_d = d_wstrb;
                    state_d     = BUSY_D;
                end else if (gnt == GNT_I) begin
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = i_addr;
                    mem_wstrb_d = '0;
                    state_d     = BUSY_I;
                end
            end
            BUSY_I: begin
                if (mem_ready) begin
                    i_rdata_d = mem_rdata;
                    i_ready_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            BUSY_D: begin
                if (mem_ready) begin
                    d_rdata_d = mem_rdata;
                    d_ready_d = 1'b1;
                    mem_req_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                mem_req_d = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wstrb_q <= '0;
            i_ready_q   <= 1'b0;
            d_ready_q   <= 1'b0;
            i_rdata_q   <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wstrb_q <= mem_wstrb_d;
            i_ready_q   <= i_ready_d;
            d_ready_q   <= d_ready_d;
            i_rdata_q   <= i_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wstrb = mem_wstrb_q;
    assign i_ready   = i_ready_q;
    assign d_ready   = d_ready_q;
    assign i_rdata   = i_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign if_stall  = i_req && !i_ready_q;
    assign mem_stall = d_req && !d_ready_q;

endmodule
